// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates the column drive, debounces a single-row hit,
// and pushes each accepted key code into a four-nibble history.
module keypad_scan #(
  parameter int DEBOUNCE = 4,
  parameter int RELEASE  = 4
) (
  input  logic        clk190hz,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] dataBus,
  output logic [3:0]  keyCode,
  output logic        keyValid
);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);
  localparam logic [3:0] REL_N = 4'(RELEASE);

  logic [1:0] state;
  logic [3:0] row_q;
  logic [3:0] deb_cnt;
  logic [3:0] rel_cnt;

  logic [3:0] deb_nxt;
  logic [3:0] rel_nxt;
  logic [3:0] col_rot;
  logic [3:0] code;
  logic       row_hit;

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] i;
    i = 2'd0;
    if (v[1]) i = 2'd1;
    if (v[2]) i = 2'd2;
    if (v[3]) i = 2'd3;
    return i;
  endfunction

  // Counters stick at 15 instead of wrapping back to zero.
  assign deb_nxt = (deb_cnt == 4'hF) ? deb_cnt : deb_cnt + 4'd1;
  assign rel_nxt = (rel_cnt == 4'hF) ? rel_cnt : rel_cnt + 4'd1;
  assign col_rot = {col[2:0], col[3]};
  assign code    = {enc(row_q), enc(col)};
  assign row_hit = $onehot(row);

  always_ff @(posedge clk190hz) begin
    if (rst) begin
      state    <= S_SCAN;
      col      <= 4'b0001;
      row_q    <= 4'b0000;
      deb_cnt  <= 4'd0;
      rel_cnt  <= 4'd0;
      dataBus  <= 16'h0000;
      keyCode  <= 4'h0;
      keyValid <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      case (state)
        S_SCAN: begin
          if (row_hit) begin
            row_q   <= row;
            deb_cnt <= 4'd0;
            state   <= S_DEB;
          end else begin
            col <= col_rot;
          end
        end
        S_DEB: begin
          if (row != row_q) begin
            state <= S_SCAN;
            col   <= col_rot;
          end else begin
            deb_cnt <= deb_nxt;
            if (deb_nxt >= DEB_N) begin
              keyValid <= 1'b1;
              keyCode  <= code;
              dataBus  <= {dataBus[11:0], code};
              rel_cnt  <= 4'd0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (row == 4'b0000) begin
            rel_cnt <= rel_nxt;
            if (rel_nxt >= REL_N) begin
              state <= S_SCAN;
              col   <= col_rot;
            end
          end else begin
            rel_cnt <= 4'd0;
          end
        end
        default: begin
          state <= S_SCAN;
          col   <= 4'b0001;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: physical keypad model driving row from col,
// directed scenarios plus random presses against a per-cycle reference.
module tb_keypad_scan;

  localparam int DEB = 4;
  localparam int REL = 4;

  logic        clk190hz = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] dataBus;
  logic [3:0]  keyCode;
  logic        keyValid;

  logic [15:0] pressed;
  logic        raw_en;
  logic [3:0]  raw_val;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  bit chk_en = 0;

  logic [3:0] row_s;
  logic       rst_s;

  keypad_scan #(.DEBOUNCE(DEB), .RELEASE(REL)) dut (
    .clk190hz(clk190hz),
    .rst(rst),
    .row(row),
    .col(col),
    .dataBus(dataBus),
    .keyCode(keyCode),
    .keyValid(keyValid)
  );

  always #5 clk190hz = ~clk190hz;

  // A pressed key closes row r onto column c while that column is driven.
  always_comb begin
    row = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] === 1'b1) row[r] = 1'b1;
    if (raw_en) row = raw_val;
  end

  always @(posedge clk190hz) begin
    cyc   <= cyc + 1;
    row_s <= row;
    rst_s <= rst;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: candidate row lock, run lengths and a history queue.
  initial begin
    int m_col = 0;
    logic [3:0] m_lock = 4'b0;
    int m_run = 0;
    int m_zrun = 0;
    bit m_acc = 0;
    bit m_valid = 0;
    int hist[$];
    int ridx;
    logic [15:0] exp_db;
    logic [3:0] exp_kc;
    forever begin
      @(negedge clk190hz);
      m_valid = 0;
      if (rst_s === 1'b1) begin
        m_col = 0; m_lock = 4'b0; m_acc = 0;
        m_run = 0; m_zrun = 0; hist.delete();
      end else if (m_lock == 4'b0) begin
        if ($countones(row_s) == 1) begin
          m_lock = row_s;
          m_run = 0;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else if (!m_acc) begin
        if (row_s != m_lock) begin
          m_lock = 4'b0;
          m_col = (m_col + 1) % 4;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            ridx = 0;
            for (int i = 0; i < 4; i++) if (m_lock[i]) ridx = i;
            hist.push_back(ridx * 4 + m_col);
            if (hist.size() > 4) void'(hist.pop_front());
            m_acc = 1;
            m_valid = 1;
            m_zrun = 0;
          end
        end
      end else begin
        m_zrun = (row_s == 4'b0) ? m_zrun + 1 : 0;
        if (m_zrun == REL) begin
          m_lock = 4'b0;
          m_acc = 0;
          m_col = (m_col + 1) % 4;
        end
      end
      exp_db = 16'h0;
      for (int i = 0; i < hist.size(); i++)
        exp_db = exp_db | (16'(hist[hist.size()-1-i]) << (4*i));
      exp_kc = (hist.size() > 0) ? 4'(hist[hist.size()-1]) : 4'h0;
      if (chk_en) begin
        check("cyc_col", col, 32'(1) << m_col);
        check("cyc_valid", keyValid, m_valid);
        check("cyc_code", keyCode, exp_kc);
        check("cyc_data", dataBus, exp_db);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk190hz);
      if (keyValid === 1'b1) pulses++;
    end
  endtask

  task automatic wait_col(input logic [3:0] c, output bit ok);
    ok = 0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (col === c) ok = 1;
      else tick(1);
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick(1);
      if (keyValid === 1'b1) ok = 1;
    end
  endtask

  task automatic press_key(input int k);
    bit ok;
    pressed = '0;
    pressed[k] = 1'b1;
    wait_valid(40, ok);
    check($sformatf("press_%0d_seen", k), ok, 1);
    tick(3);
    pressed = '0;
    tick(REL + 6);
  endtask

  initial begin
    bit ok;
    int p0, det, changes, k1, k2;
    logic [3:0] c0;
    rst = 1'b1; pressed = '0; raw_en = 1'b0; raw_val = 4'b0;
    tick(2);
    check("rst_col", col, 4'b0001);
    check("rst_data", dataBus, 16'h0000);
    check("rst_valid", keyValid, 0);
    check("rst_code", keyCode, 4'h0);
    chk_en = 1;
    rst = 1'b0;

    wait_col(4'b0010, ok);
    check("wait_col5", ok, 1);
    p0 = pulses;
    pressed[5] = 1'b1;
    det = cyc + 1;
    wait_valid(20, ok);
    check("key5_seen", ok, 1);
    check("key5_latency", cyc - det, 4);
    check("key5_code", keyCode, 4'h5);
    check("key5_data", dataBus, 16'h0005);
    tick(14);
    pressed = '0;
    tick(10);
    check("key5_pulses", pulses - p0, 1);

    p0 = pulses;
    press_key(1); press_key(2); press_key(3); press_key(4);
    check("seq_pulses", pulses - p0, 4);
    check("seq_data", dataBus, 16'h1234);
    press_key(15);
    check("keyF_data", dataBus, 16'h234F);
    check("keyF_code", keyCode, 4'hF);

    p0 = pulses;
    raw_en = 1'b1; raw_val = 4'b0010;
    tick(2);
    raw_val = 4'b0000;
    tick(4);
    c0 = col;
    tick(1);
    check("bounce_scan", col, {c0[2:0], c0[3]});
    raw_en = 1'b0;
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_data", dataBus, 16'h234F);

    raw_en = 1'b1; raw_val = 4'b0011;
    changes = 0;
    repeat (12) begin
      c0 = col;
      tick(1);
      if (col !== c0) changes++;
    end
    raw_en = 1'b0;
    check("tworow_rotate", changes, 12);
    check("tworow_pulses", pulses - p0, 0);

    rst = 1'b1; tick(1); rst = 1'b0;
    wait_col(4'b1000, ok);
    check("wait_col7", ok, 1);
    pressed = '0; pressed[7] = 1'b1;
    p0 = pulses;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst7_valid_a", keyValid, 0);
    tick(1);
    check("rst7_valid_b", keyValid, 0);
    rst = 1'b0;
    check("rst7_nopulse", pulses - p0, 0);
    wait_valid(40, ok);
    check("key7_seen", ok, 1);
    check("key7_code", keyCode, 4'h7);
    check("key7_data", dataBus, 16'h0007);
    tick(10);
    check("key7_pulses", pulses - p0, 1);
    pressed = '0;
    tick(REL + 6);

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          pressed = '0;
          pressed[$urandom_range(0, 15)] = 1'b1;
          tick($urandom_range(1, 25));
          pressed = '0;
          tick($urandom_range(0, 8));
        end
        6: begin
          k1 = $urandom_range(0, 15);
          k2 = $urandom_range(0, 15);
          pressed = '0; pressed[k1] = 1'b1;
          tick($urandom_range(1, 12));
          pressed[k2] = 1'b1;
          tick($urandom_range(1, 12));
          pressed[k1] = 1'b0;
          tick($urandom_range(0, 10));
          pressed = '0;
          tick($urandom_range(0, 8));
        end
        7: begin
          raw_en = 1'b1;
          repeat ($urandom_range(1, 6)) begin
            raw_val = 4'($urandom_range(0, 15));
            tick(1);
          end
          raw_en = 1'b0;
          tick($urandom_range(0, 6));
        end
        8: begin
          pressed = '0;
          pressed[$urandom_range(0, 15)] = 1'b1;
          tick($urandom_range(0, 10));
          rst = 1'b1;
          tick($urandom_range(1, 2));
          rst = 1'b0;
          tick($urandom_range(0, 12));
          pressed = '0;
          tick($urandom_range(0, 8));
        end
        default: begin
          k1 = $urandom_range(0, 15);
          repeat ($urandom_range(2, 6)) begin
            pressed = '0; pressed[k1] = 1'b1;
            tick($urandom_range(1, 5));
            pressed = '0;
            tick($urandom_range(1, 5));
          end
        end
      endcase
    end
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive matching press samples required before a key is accepted (legal 1..15).
REQ-002 SHALL have parameter RELEASE, default 4: consecutive all-zero row samples required before the key counts as released (legal 1..15).
REQ-003 SHALL have port clk190hz, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port row, input, 4 bits: keypad row sense, active-high, sampled on every clock.
REQ-006 SHALL have port col, output, 4 bits: one-hot keypad column drive, registered.
REQ-007 SHALL have port dataBus, output, 16 bits: the last four accepted key codes, newest in bits [3:0], registered.
REQ-008 SHALL have port keyCode, output, 4 bits: code of the most recently accepted key, registered.
REQ-009 SHALL have port keyValid, output, 1 bit: one-cycle pulse marking an accepted key, registered.

Function
REQ-010 SHALL implement the states SCAN, DEBOUNCE and WAIT_RELEASE.
REQ-011 SHALL define the key code as r*4+c, where r is the index of the asserted row bit and c is the index of the asserted col bit (both 0..3).
REQ-012 In SCAN with row==0 or row not one-hot, SHALL rotate col one step per cycle (0001->0010->0100->1000->0001).
REQ-013 In SCAN with row one-hot, SHALL latch row and the current col, hold col frozen, clear the counter, and enter DEBOUNCE on the next cycle.
REQ-014 In DEBOUNCE, SHALL increment the counter on each cycle where row equals the latched row.
REQ-015 In DEBOUNCE, on any cycle where row differs from the latched row, SHALL return to SCAN, advance col one step, and produce no keyValid.
REQ-016 When the counter reaches DEBOUNCE matches, SHALL in that same edge set keyValid=1, set keyCode to the key code, shift dataBus to {dataBus[11:0], code}, and enter WAIT_RELEASE.
REQ-017 Latency SHALL be fixed: keyValid is high in cycle T+DEBOUNCE+1, where T is the SCAN detect cycle, given a stable press.
REQ-018 keyValid SHALL be high for exactly one cycle per accepted press.
REQ-019 keyCode and dataBus SHALL change only on a keyValid cycle.
REQ-020 In WAIT_RELEASE, col SHALL remain frozen.
REQ-021 In WAIT_RELEASE, each cycle with row==0 SHALL increment the release counter, and any row!=0 SHALL clear it.
REQ-022 After RELEASE consecutive zero samples, SHALL return to SCAN with col advanced one step.
REQ-023 A held key SHALL never repeat, whatever the hold length.
REQ-024 Pressing a second key while the first is held SHALL be ignored until both keys are released.
REQ-025 Counters SHALL saturate and never wrap.
REQ-026 On dataBus shift, the oldest nibble (bits [15:12]) SHALL be discarded.

Reset
REQ-027 When rst=1 at a clock edge, SHALL set state=SCAN, col=4'b0001, dataBus=16'h0000, keyCode=4'h0, keyValid=0 and clear both counters.
REQ-028 rst SHALL take priority over all other activity, including mid-DEBOUNCE and mid-WAIT_RELEASE.
REQ-029 After rst, a key still held SHALL be re-detected from SCAN as a new press.

Verification
REQ-030 Apply rst for 2 cycles -> col=0001, dataBus=0x0000, keyValid=0.
REQ-031 Hold row=0010 whenever col=0010 (key 5) for 20 cycles, then release; DEBOUNCE=4 -> exactly one keyValid, 5 cycles after detect, keyCode=5, dataBus=0x0005.
REQ-032 Press and release keys 1, 2, 3, 4 in sequence -> four keyValid pulses, dataBus=0x1234; then key F -> dataBus=0x234F.
REQ-033 Bounce: row asserted for 2 cycles, then 0 -> no keyValid, scanning resumes, dataBus unchanged.
REQ-034 Assert row=0011 (two rows) -> no keyValid, col keeps rotating.
REQ-035 Assert rst during DEBOUNCE of key 7 with the key still held -> no pulse during reset; after rst, key 7 is accepted once, dataBus=0x0007.
